// File: rtl/bus_round_robin_arbiter.sv
// Round-robin owner arbiter for the shared system bus; snoops begin/end/error to track ownership.
// Optional watchdog (define ARBITER_WATCHDOG_EN) forces end+error on transactions stuck in ACTIVE.
module bus_round_robin_arbiter #(
    parameter int NR_OF_MASTERS  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NR_OF_MASTERS-1:0] busRequests,
    input  logic                     beginTransactionIn,
    input  logic                     endTransactionIn,
    input  logic                     busErrorIn,
    output logic [NR_OF_MASTERS-1:0] busGrants,
    output logic                     endTransactionOut,
    output logic                     busErrorOut,
    output logic                     busIdle,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = $clog2(NR_OF_MASTERS);

    if (NR_OF_MASTERS < 2 || NR_OF_MASTERS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("bus_round_robin_arbiter: parameter out of range");
    end

    // Handshake: a master owns the bus while its grant bit is high; it must keep its
    // request high until its transaction ends, and the arbiter follows the transaction
    // only by watching begin/end/error on the shared bus.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [NR_OF_MASTERS-1:0] grants_q, grants_d;
    logic [IDX_W-1:0]         last_q, last_d;

    logic                     win_found;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         cand_idx;
    logic [NR_OF_MASTERS-1:0] win_onehot;
    logic                     owner_req;
    logic                     wd_expire;

    // Scan upward from the master after the last owner, wrapping once around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand_idx  = last_q;
        for (int k = 1; k <= NR_OF_MASTERS; k++) begin
            cand_idx = IDX_W'((int'(last_q) + k) % NR_OF_MASTERS);
            if (!win_found && busRequests[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_onehot = {{(NR_OF_MASTERS-1){1'b0}}, 1'b1} << win_idx;
    assign owner_req  = busRequests[last_q];

    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        last_d   = last_q;
        case (state_q)
            // RELEASE re-arbitrates on the same edge it leaves, so no IDLE hop is needed.
            ST_IDLE, ST_RELEASE: begin
                grants_d = '0;
                state_d  = ST_IDLE;
                if (win_found) begin
                    grants_d = win_onehot;
                    last_d   = win_idx;
                    state_d  = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (beginTransactionIn) begin
                    state_d = ST_ACTIVE;
                end else if (!owner_req) begin
                    state_d  = ST_RELEASE;
                    grants_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (endTransactionIn || busErrorIn || wd_expire) begin
                    state_d  = ST_RELEASE;
                    grants_d = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grants_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grants_q <= '0;
            last_q   <= IDX_W'(NR_OF_MASTERS - 1);
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            last_q   <= last_d;
        end
    end

`ifdef ARBITER_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_pulse_q, wd_pulse_d;

    // The count includes the current ACTIVE cycle, so expiry lands after exactly TIMEOUT_CYCLES.
    always_comb begin
        wd_cnt_d   = (state_q == ST_ACTIVE) ? wd_cnt_q + 16'd1 : 16'd0;
        wd_expire  = (state_q == ST_ACTIVE) &&
                     (({1'b0, wd_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));
        wd_pulse_d = wd_expire && !(endTransactionIn || busErrorIn);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q   <= '0;
            wd_pulse_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wd_pulse_q <= wd_pulse_d;
        end
    end

    assign endTransactionOut = wd_pulse_q;
    assign busErrorOut       = wd_pulse_q;
`else
    assign wd_expire         = 1'b0;
    assign endTransactionOut = 1'b0;
    assign busErrorOut       = 1'b0;
`endif

    assign busGrants = grants_q;
    assign busIdle   = (state_q == ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Directed + lightly randomized bench for bus_round_robin_arbiter (4 masters, timeout 8).
// Grant events are checked against an expected queue; cycle-exact points are checked inline.
module tb_bus_round_robin_arbiter;

    localparam int N = 4;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANTED = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] busRequests = '0;
    logic         beginTransactionIn = 1'b0;
    logic         endTransactionIn = 1'b0;
    logic         busErrorIn = 1'b0;
    logic [N-1:0] busGrants;
    logic         endTransactionOut;
    logic         busErrorOut;
    logic         busIdle;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] prev_grant = '0;

    bus_round_robin_arbiter #(
        .NR_OF_MASTERS (N),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .busRequests       (busRequests),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn  (endTransactionIn),
        .busErrorIn        (busErrorIn),
        .busGrants         (busGrants),
        .endTransactionOut (endTransactionOut),
        .busErrorOut       (busErrorOut),
        .busIdle           (busIdle),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (busGrants == '0 && n < 20) begin
            tick();
            n++;
        end
        check("grant_wait", 32'(busGrants != '0), 32'd1);
    endtask

    // Drive one owned transaction from GRANTED: begin, hold cycles, then end or error.
    task automatic do_txn(input int hold, input logic [N-1:0] req_at_end, input bit use_err);
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        check("txn_active", 32'(dbg_state), 32'(S_ACTIVE));
        repeat (hold) tick();
        busRequests = req_at_end;
        if (use_err) busErrorIn = 1'b1;
        else endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
    endtask

    // scoreboard monitor: every new owner is popped against the expected queue
    always @(negedge clock) begin
        if (!reset) begin
            check("onehot", 32'($onehot0(busGrants)), 32'd1);
            if (busGrants != '0 && busGrants != prev_grant) begin
                if (prev_grant != '0) check("owner_gap", 32'(prev_grant), 32'd0);
                if (exp_q.size() == 0) check("grant_unexpected", 32'(busGrants), 32'd0);
                else check("grant_order", 32'(busGrants), 32'(exp_q.pop_front()));
            end
        end
        prev_grant = busGrants;
    end

    initial begin
        // reset, then idle for 5 cycles
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_grants", 32'(busGrants), 32'd0);
            check("rst_idle", 32'(busIdle), 32'd1);
            check("rst_eto", 32'(endTransactionOut), 32'd0);
            check("rst_beo", 32'(busErrorOut), 32'd0);
        end
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // begin with no owner is ignored
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        check("idle_begin_ignored", 32'(busIdle), 32'd1);

        // all four request: strict rotation with one zero cycle between owners
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        busRequests = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant();
            check("rr_granted_state", 32'(dbg_state), 32'(S_GRANTED));
            do_txn(2, (i == 4) ? 4'b0000 : 4'b1111, 1'b0);
            check("rr_release_zero", 32'(busGrants), 32'd0);
            check("rr_release_state", 32'(dbg_state), 32'(S_RELEASE));
            tick();
            if (i < 4) check("rr_regrant_next", 32'(busGrants != '0), 32'd1);
            else check("rr_final_idle", 32'(busIdle), 32'd1);
        end

        // single requester regranted after the turnaround cycle
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        busRequests = 4'b0100;
        wait_grant();
        endTransactionIn = 1'b1;
        busErrorIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        check("granted_end_ignored", 32'(dbg_state), 32'(S_GRANTED));
        check("granted_end_grant", 32'(busGrants), 32'(4'b0100));
        do_txn($urandom_range(0, 4), 4'b0100, 1'b1);
        check("solo_t1_zero", 32'(busGrants), 32'd0);
        tick();
        check("solo_t2_regrant", 32'(busGrants), 32'(4'b0100));
        do_txn($urandom_range(0, 4), 4'b0000, 1'b0);
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        check("release_begin_ignored", 32'(busIdle), 32'd1);
        check("release_begin_grants", 32'(busGrants), 32'd0);

        // abandoned grant: master 1 drops before begin, pending master 3 follows
        exp_q.push_back(4'b0010);
        busRequests = 4'b0010;
        wait_grant();
        exp_q.push_back(4'b1000);
        busRequests = 4'b1000;
        tick();
        check("abandon_zero", 32'(busGrants), 32'd0);
        check("abandon_state", 32'(dbg_state), 32'(S_RELEASE));
        tick();
        check("abandon_next", 32'(busGrants), 32'(4'b1000));
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        busRequests = 4'b1111;
        repeat (3) tick();
        check("active_others_ignored", 32'(busGrants), 32'(4'b1000));

        // reset while master 3 is mid-transaction
        reset = 1'b1;
        tick();
        check("midrst_grants", 32'(busGrants), 32'd0);
        check("midrst_idle", 32'(busIdle), 32'd1);
        check("midrst_eto", 32'(endTransactionOut), 32'd0);
        check("midrst_beo", 32'(busErrorOut), 32'd0);
        reset = 1'b0;
        exp_q.push_back(4'b0001);
        busRequests = 4'b0011;
        tick();
        check("midrst_m0_wins", 32'(busGrants), 32'(4'b0001));
        do_txn($urandom_range(0, 3), 4'b0000, 1'b0);
        tick();
        check("midrst_done_idle", 32'(busIdle), 32'd1);

        // watchdog behaviour
        exp_q.push_back(4'b1000);
        busRequests = 4'b1000;
        wait_grant();
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        busRequests = 4'b0000;
`ifdef ARBITER_WATCHDOG_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wd_no_early_pulse", 32'(endTransactionOut), 32'd0);
            check("wd_still_owned", 32'(busGrants), 32'(4'b1000));
        end
        tick();
        check("wd_eto_pulse", 32'(endTransactionOut), 32'd1);
        check("wd_beo_pulse", 32'(busErrorOut), 32'd1);
        check("wd_grants_zero", 32'(busGrants), 32'd0);
        tick();
        check("wd_pulse_one_cycle", 32'(endTransactionOut), 32'd0);
        check("wd_back_idle", 32'(busIdle), 32'd1);

        exp_q.push_back(4'b0001);
        busRequests = 4'b0001;
        wait_grant();
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        busRequests = 4'b0000;
        repeat (7) tick();
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        check("wd_tie_eto", 32'(endTransactionOut), 32'd0);
        check("wd_tie_beo", 32'(busErrorOut), 32'd0);
        check("wd_tie_zero", 32'(busGrants), 32'd0);
`else
        repeat (20) tick();
        check("nowd_still_active", 32'(dbg_state), 32'(S_ACTIVE));
        check("nowd_still_owned", 32'(busGrants), 32'(4'b1000));
        check("nowd_eto", 32'(endTransactionOut), 32'd0);
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        check("nowd_release", 32'(busGrants), 32'd0);
        check("nowd_beo", 32'(busErrorOut), 32'd0);
`endif
        repeat (2) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_round_robin_arbiter.md
# bus_round_robin_arbiter

Round-robin arbiter that shares the single system bus (the shared address/data bus feeding the SDRAM controller and SPI-flash controller) among up to NR_OF_MASTERS bus masters: CPU instruction/data caches, camera DMA, display DMA. It grants exclusive bus ownership to one requester at a time, tracks the transaction by snooping begin/end/error on the shared bus, and releases ownership with one idle turnaround cycle. An optional watchdog terminates transactions that never complete.

## Interface
- NR_OF_MASTERS, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 1023: watchdog limit in cycles of ACTIVE, 1..65535; only used with the watchdog compiled in.

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset.
- busRequests  in  NR_OF_MASTERS  bit i high = master i wants the bus; held until its transaction ends.
- beginTransactionIn  in  1  shared-bus begin (OR of all masters).
- endTransactionIn  in  1  shared-bus end (OR of all slaves and masters).
- busErrorIn  in  1  shared-bus error.
- busGrants  out  NR_OF_MASTERS  registered, one-hot or all-zero.
- endTransactionOut  out  1  arbiter-driven end, used only on watchdog expiry.
- busErrorOut  out  1  arbiter-driven error, used only on watchdog expiry.
- busIdle  out  1  high in IDLE state.

## Operation
- States: IDLE, GRANTED, ACTIVE, RELEASE.
- IDLE: if busRequests != 0, select winner, grant it, go GRANTED; else stay.
- Winner: first set bit scanning from (lastGrant+1) mod NR_OF_MASTERS upward with wrap; lastGrant updates on every grant. After reset lastGrant = NR_OF_MASTERS-1, so master 0 has highest priority first.
- GRANTED: beginTransactionIn high -> ACTIVE. Granted master's request low without begin -> RELEASE (abandoned grant).
- ACTIVE: endTransactionIn or busErrorIn high -> RELEASE. Requests of other masters are ignored.
- RELEASE: grants all zero for exactly one cycle (bus turnaround), then arbitrate as in IDLE on the same edge: a pending request produces a grant without passing through IDLE.
- Granted master holding its request across RELEASE does not keep the bus if another master requests (round-robin fairness); if it is the only requester it is granted again.
- Begin seen in IDLE or RELEASE (no owner): ignored, no state change.
- End/error in GRANTED: ignored.
- Simultaneous end and watchdog expiry: treated as normal end; no arbiter error pulses.

## Timing
- Reset values: busGrants = 0, endTransactionOut = 0, busErrorOut = 0, busIdle = 1, state IDLE, watchdog counter 0.
- Reset mid-transaction: all outputs return to reset values the cycle after reset is sampled; no end/error pulse generated.
- Request sampled in IDLE at edge c -> grant visible after edge c (cycle c+1).
- End/error sampled at edge t -> grants zero in cycle t+1 (RELEASE); next grant visible in cycle t+2.
- Minimum owner-to-owner gap: one cycle with all grants zero.
- busGrants is never multi-hot; changes only on edges entering GRANTED or RELEASE.

## Configuration
- ARBITER_WATCHDOG_EN defined: 16-bit counter clears on entry to ACTIVE, increments each ACTIVE cycle; when it equals TIMEOUT_CYCLES with no end/error that cycle, endTransactionOut and busErrorOut pulse high for exactly one cycle (the RELEASE cycle) and state goes RELEASE.
- Not defined: no counter; endTransactionOut and busErrorOut tied 0; ACTIVE waits indefinitely.

## Test plan
- Reset, busRequests=4'b0000 for 5 cycles -> busGrants=0, busIdle=1, both error outputs 0.
- busRequests=4'b1111 held, each transaction begin 1 cycle after grant, end 3 cycles later -> grant order 0001,0010,0100,1000,0001 with exactly one zero-grant cycle between owners.
- Only master 2 requests, begin, end at edge t -> busGrants=0100 at t+2 again after zero cycle at t+1.
- Master 1 granted, drops request before begin -> grants 0 next cycle, master 3 (pending) granted the cycle after.
- Watchdog on, TIMEOUT_CYCLES=8, begin without end -> after 8 ACTIVE cycles endTransactionOut=busErrorOut=1 for one cycle, grants 0 that cycle; end on the expiry cycle -> no error pulse.
- reset asserted during ACTIVE with master 3 granted -> next cycle busGrants=0, busIdle=1; after release master 0 wins over master 1 when both request.
